output_uart_bridge: RTL

OUTPUT_UART_BRIDGE -- requirements
Module: output_uart_bridge

---
 rtl/riscv_cpu_pkg.sv | 22 ++
 rtl/word_fifo.sv | 52 +++++
 rtl/output_uart_bridge.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/riscv_cpu_pkg.sv
// rtl/riscv_cpu_pkg.sv - UART transmitter constants and state encoding; OUTPUT_UART_PARITY_EN adds the PARITY state
package riscv_cpu_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_STOP_BITS = 1;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_LOAD   = 3'd1,
        TX_START  = 3'd2,
        TX_DATA   = 3'd3,
`ifdef OUTPUT_UART_PARITY_EN
        TX_PARITY = 3'd4,
`endif
        TX_STOP   = 3'd5
    } tx_state_t;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/word_fifo.sv
// rtl/word_fifo.sv - synchronous word FIFO; a push while full is accepted only alongside a pop
module word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // When full, the slot being written is the one being read out this cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/output_uart_bridge.sv
// rtl/output_uart_bridge.sv - buffered CPU-word to UART transmitter; OUTPUT_UART_PARITY_EN adds an even parity bit
module output_uart_bridge
    import riscv_cpu_pkg::*;
#(
    parameter int WORD_SIZE    = 32,
    parameter int FIFO_DEPTH   = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          output_en,
    input  logic [WORD_SIZE-1:0]          data_out,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int NBYTES = WORD_SIZE / UART_DATA_BITS;
    localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int TW     = $clog2(CLKS_PER_BIT);

    localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);
    localparam logic [2:0]    LAST_DATA = 3'(UART_DATA_BITS - 1);
    localparam logic [2:0]    LAST_STOP = 3'(UART_STOP_BITS - 1);

    tx_state_t            state, state_n;
    logic [TW-1:0]        timer, timer_n, tick_next;
    logic [2:0]           bit_cnt, bit_n;
    logic [BW-1:0]        byte_cnt, byte_n;
    logic [WORD_SIZE-1:0] sr, sr_n;
    logic                 tx_n;
    logic                 last_tick;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic                 drop;
    logic [WORD_SIZE-1:0] fifo_rdata;
`ifdef OUTPUT_UART_PARITY_EN
    logic                 par, par_n;
`endif

    word_fifo #(
        .WIDTH (WORD_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (output_en),
        .wdata (data_out),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    assign drop      = output_en && full && !pop;
    assign busy      = !empty || (state != TX_IDLE);
    assign last_tick = (timer == LAST_TICK);
    assign tick_next = last_tick ? '0 : timer + 1'b1;

    always_comb begin
        state_n = state;
        timer_n = '0;
        bit_n   = bit_cnt;
        byte_n  = byte_cnt;
        sr_n    = sr;
        pop     = 1'b0;
        tx_n    = 1'b1;
`ifdef OUTPUT_UART_PARITY_EN
        par_n   = par;
`endif
        case (state)
            TX_IDLE: begin
                if (!empty) state_n = TX_LOAD;
            end
            TX_LOAD: begin
                pop     = 1'b1;
                sr_n    = fifo_rdata;
                byte_n  = '0;
                bit_n   = '0;
                state_n = TX_START;
`ifdef OUTPUT_UART_PARITY_EN
                par_n   = even_parity(fifo_rdata[7:0]);
`endif
            end
            TX_START: begin
                timer_n = tick_next;
                if (last_tick) begin
                    bit_n   = '0;
                    state_n = TX_DATA;
                end
            end
            TX_DATA: begin
                timer_n = tick_next;
                if (last_tick) begin
                    // Shifting one bit per period leaves the next byte in sr[7:0] after eight bits.
                    sr_n = sr >> 1;
                    if (bit_cnt == LAST_DATA) begin
                        bit_n = '0;
`ifdef OUTPUT_UART_PARITY_EN
                        state_n = TX_PARITY;
`else
                        state_n = TX_STOP;
`endif
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                    end
                end
            end
`ifdef OUTPUT_UART_PARITY_EN
            TX_PARITY: begin
                timer_n = tick_next;
                if (last_tick) begin
                    bit_n   = '0;
                    state_n = TX_STOP;
                end
            end
`endif
            TX_STOP: begin
                timer_n = tick_next;
                if (last_tick) begin
                    if (bit_cnt != LAST_STOP) begin
                        bit_n = bit_cnt + 1'b1;
                    end else begin
                        bit_n = '0;
                        if (byte_cnt != LAST_BYTE) begin
                            byte_n  = byte_cnt + 1'b1;
                            state_n = TX_START;
`ifdef OUTPUT_UART_PARITY_EN
                            par_n   = even_parity(sr[7:0]);
`endif
                        end else if (!empty) begin
                            state_n = TX_LOAD;
                        end else begin
                            state_n = TX_IDLE;
                        end
                    end
                end
            end
            default: state_n = TX_IDLE;
        endcase

        // tx is registered from the next state so the line level lines up with the state.
        case (state_n)
            TX_START:  tx_n = 1'b0;
            TX_DATA:   tx_n = sr_n[0];
`ifdef OUTPUT_UART_PARITY_EN
            TX_PARITY: tx_n = par_n;
`endif
            default:   tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= TX_IDLE;
            timer    <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            sr       <= '0;
            tx       <= 1'b1;
            overflow <= 1'b0;
`ifdef OUTPUT_UART_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            bit_cnt  <= bit_n;
            byte_cnt <= byte_n;
            sr       <= sr_n;
            tx       <= tx_n;
            if (drop) overflow <= 1'b1;
`ifdef OUTPUT_UART_PARITY_EN
            par      <= par_n;
`endif
        end
    end

endmodule
